// File: rtl/demo_mode_sequencer.sv
// Time-slot scheduler that hands the board displays between demo modes with a blanking gap.
// Optional feature macro: SEQ_AUTO_ADVANCE_EN (tick-driven dwell countdown and auto-advance).
module demo_mode_sequencer #(
  parameter int unsigned NUM_MODES    = 4,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tick_in,
  input  logic       next_pulse,
  input  logic       prev_pulse,
  input  logic       pause_pulse,
  input  logic [3:0] dwell_sw,
  output logic [1:0] mode_out,
  output logic [3:0] mode_en,
  output logic       blank_out,
  output logic       paused_out,
  output logic [4:0] dwell_left,
  output logic       mode_chg_pulse
);

  localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0] LAST_MODE = 2'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             ret_paused, ret_paused_nxt;
  logic [CNT_W-1:0] blank_cnt, blank_cnt_nxt;
  logic [1:0]       mode_nxt;
  logic [3:0]       mode_en_nxt;
  logic             blank_nxt;
  logic             paused_nxt;
  logic [4:0]       dwell_nxt;
  logic             chg_nxt;
  logic             step;
  logic [1:0]       step_mode;
  logic [1:0]       mode_inc;
  logic [1:0]       mode_dec;
  logic             tick_run;

`ifdef SEQ_AUTO_ADVANCE_EN
  assign tick_run = tick_in;
`else
  // Ticks have no effect when auto-advance is compiled out.
  logic unused_tick;
  assign unused_tick = tick_in;
  assign tick_run    = 1'b0;
`endif

  assign mode_inc = (mode_out == LAST_MODE) ? 2'd0 : mode_out + 2'd1;
  assign mode_dec = (mode_out == 2'd0) ? LAST_MODE : mode_out - 2'd1;

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= ST_BLANK;
      ret_paused     <= 1'b0;
      blank_cnt      <= BLANK_LOAD;
      mode_out       <= 2'd0;
      mode_en        <= 4'd0;
      blank_out      <= 1'b1;
      paused_out     <= 1'b0;
      dwell_left     <= 5'd0;
      mode_chg_pulse <= 1'b0;
    end else begin
      state          <= state_nxt;
      ret_paused     <= ret_paused_nxt;
      blank_cnt      <= blank_cnt_nxt;
      mode_out       <= mode_nxt;
      mode_en        <= mode_en_nxt;
      blank_out      <= blank_nxt;
      paused_out     <= paused_nxt;
      dwell_left     <= dwell_nxt;
      mode_chg_pulse <= chg_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    ret_paused_nxt = ret_paused;
    blank_cnt_nxt  = blank_cnt;
    mode_nxt       = mode_out;
    mode_en_nxt    = mode_en;
    blank_nxt      = blank_out;
    paused_nxt     = paused_out;
    dwell_nxt      = dwell_left;
    chg_nxt        = 1'b0;
    step           = 1'b0;
    step_mode      = mode_out;

    case (state)
      ST_BLANK: begin
        if (blank_cnt == '0) begin
          state_nxt   = ret_paused ? ST_PAUSE : ST_RUN;
          dwell_nxt   = 5'(dwell_sw) + 5'd1;
          mode_en_nxt = 4'(4'd1 << mode_out);
          blank_nxt   = 1'b0;
          chg_nxt     = 1'b1;
        end else begin
          blank_cnt_nxt = blank_cnt - CNT_W'(1);
        end
      end
      ST_RUN, ST_PAUSE: begin
        // Pause beats a step, a single-key step beats a tick.
        if (pause_pulse) begin
          state_nxt  = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
          paused_nxt = ~paused_out;
        end else if (next_pulse ^ prev_pulse) begin
          step      = 1'b1;
          step_mode = next_pulse ? mode_inc : mode_dec;
        end else if ((state == ST_RUN) && tick_run) begin
          if (dwell_left == 5'd1) begin
            step      = 1'b1;
            step_mode = mode_inc;
          end else begin
            dwell_nxt = dwell_left - 5'd1;
          end
        end
      end
      default: state_nxt = ST_BLANK;
    endcase

    if (step) begin
      state_nxt      = ST_BLANK;
      ret_paused_nxt = (state == ST_PAUSE);
      blank_cnt_nxt  = BLANK_LOAD;
      mode_nxt       = step_mode;
      mode_en_nxt    = 4'd0;
      blank_nxt      = 1'b1;
      dwell_nxt      = 5'd0;
    end
  end

endmodule

// File: tb/tb_demo_mode_sequencer.sv
// Self-checking bench for demo_mode_sequencer: timestamp-based ownership model plus directed literal checks.
module tb_demo_mode_sequencer;

  localparam int NM = 4;
  localparam int BC = 16;
`ifdef SEQ_AUTO_ADVANCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int DW_AFTER_TICK = AUTO ? 2 : 3;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       tick_in = 1'b0;
  logic       next_pulse = 1'b0;
  logic       prev_pulse = 1'b0;
  logic       pause_pulse = 1'b0;
  logic [3:0] dwell_sw = 4'd2;
  logic [1:0] mode_out;
  logic [3:0] mode_en;
  logic       blank_out;
  logic       paused_out;
  logic [4:0] dwell_left;
  logic       mode_chg_pulse;

  int tests = 0;
  int fails = 0;

  demo_mode_sequencer #(.NUM_MODES(NM), .BLANK_CYCLES(BC)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .tick_in       (tick_in),
    .next_pulse    (next_pulse),
    .prev_pulse    (prev_pulse),
    .pause_pulse   (pause_pulse),
    .dwell_sw      (dwell_sw),
    .mode_out      (mode_out),
    .mode_en       (mode_en),
    .blank_out     (blank_out),
    .paused_out    (paused_out),
    .dwell_left    (dwell_left),
    .mode_chg_pulse(mode_chg_pulse)
  );

  initial forever #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a mode owns the displays from cycle m_blank_end onward; earlier cycles are blank.
  int cyc = 0;
  bit m_valid = 1'b0;
  int m_mode = 0;
  bit m_paused = 1'b0;
  int m_dwell = 0;
  int m_blank_end = 0;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (rst_in) begin
      m_valid     <= 1'b1;
      m_mode      <= 0;
      m_paused    <= 1'b0;
      m_dwell     <= 0;
      m_blank_end <= cyc + 1 + BC;
    end else if (m_valid) begin
      if (cyc < m_blank_end) begin
        if (cyc + 1 == m_blank_end) m_dwell <= int'(dwell_sw) + 1;
      end else if (pause_pulse) begin
        m_paused <= !m_paused;
      end else if (next_pulse != prev_pulse) begin
        m_mode      <= next_pulse ? (m_mode + 1) % NM : (m_mode + NM - 1) % NM;
        m_blank_end <= cyc + 1 + BC;
        m_dwell     <= 0;
      end else if (tick_in && AUTO && !m_paused) begin
        if (m_dwell == 1) begin
          m_mode      <= (m_mode + 1) % NM;
          m_blank_end <= cyc + 1 + BC;
          m_dwell     <= 0;
        end else begin
          m_dwell <= m_dwell - 1;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      chk("model mode_out", int'(mode_out), m_mode);
      chk("model blank_out", int'(blank_out), (cyc < m_blank_end) ? 1 : 0);
      chk("model mode_en", int'(mode_en), (cyc < m_blank_end) ? 0 : (1 << m_mode));
      chk("model mode_chg_pulse", int'(mode_chg_pulse), (cyc == m_blank_end) ? 1 : 0);
      chk("model paused_out", int'(paused_out), int'(m_paused));
      chk("model dwell_left", int'(dwell_left), m_dwell);
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    go(2);
    rst_in = 1'b0;
    chk("reset blank_out", int'(blank_out), 1);
    chk("reset mode_en", int'(mode_en), 0);
    chk("reset dwell_left", int'(dwell_left), 0);
    go(15);
    chk("blank cycle 16", int'(blank_out), 1);
    go(1);
    chk("first mode_en", int'(mode_en), 1);
    chk("first chg pulse", int'(mode_chg_pulse), 1);
    chk("first dwell", int'(dwell_left), 3);
    go(1);
    chk("chg pulse ends", int'(mode_chg_pulse), 0);

    for (int i = 0; i < 12; i++) begin
      tick_in = 1'b1; go(1); tick_in = 1'b0;
      if (i == 0) chk("dwell after tick", int'(dwell_left), DW_AFTER_TICK);
      go(19);
    end
    chk("mode after 12 ticks", int'(mode_out), 0);
    chk("dwell after 12 ticks", int'(dwell_left), 3);

    prev_pulse = 1'b1; go(1); prev_pulse = 1'b0;
    chk("prev wrap mode", int'(mode_out), 3);
    chk("prev blank", int'(blank_out), 1);
    go(16);
    chk("prev mode_en", int'(mode_en), 8);
    chk("prev chg", int'(mode_chg_pulse), 1);
    next_pulse = 1'b1; go(1); next_pulse = 1'b0;
    chk("next wrap mode", int'(mode_out), 0);
    go(16);
    chk("next mode_en", int'(mode_en), 1);

    pause_pulse = 1'b1; go(1); pause_pulse = 1'b0;
    chk("pause paused_out", int'(paused_out), 1);
    chk("pause no blank", int'(blank_out), 0);
    for (int i = 0; i < 5; i++) begin
      tick_in = 1'b1; go(1); tick_in = 1'b0; go(2);
    end
    chk("paused dwell hold", int'(dwell_left), 3);
    next_pulse = 1'b1; go(1); next_pulse = 1'b0;
    chk("paused step mode", int'(mode_out), 1);
    chk("paused step paused", int'(paused_out), 1);
    go(16);
    chk("paused step mode_en", int'(mode_en), 2);
    chk("paused kept", int'(paused_out), 1);
    pause_pulse = 1'b1; go(1); pause_pulse = 1'b0;
    chk("resume", int'(paused_out), 0);
    tick_in = 1'b1; go(1); tick_in = 1'b0;
    chk("resume dwell", int'(dwell_left), DW_AFTER_TICK);
    go(3);

    next_pulse = 1'b1; prev_pulse = 1'b1; go(1);
    next_pulse = 1'b0; prev_pulse = 1'b0;
    chk("next+prev no blank", int'(blank_out), 0);
    chk("next+prev mode", int'(mode_out), 1);
    pause_pulse = 1'b1; next_pulse = 1'b1; go(1);
    pause_pulse = 1'b0; next_pulse = 1'b0;
    chk("pause+next paused", int'(paused_out), 1);
    chk("pause+next mode", int'(mode_out), 1);
    chk("pause+next blank", int'(blank_out), 0);
    pause_pulse = 1'b1; go(1); pause_pulse = 1'b0;

    next_pulse = 1'b1; go(1); next_pulse = 1'b0;
    go(2);
    prev_pulse = 1'b1; go(1); prev_pulse = 1'b0;
    next_pulse = 1'b1; go(1); next_pulse = 1'b0;
    pause_pulse = 1'b1; go(1); pause_pulse = 1'b0;
    go(11);
    chk("blank keys ignored mode", int'(mode_out), 2);
    chk("blank keys ignored pause", int'(paused_out), 0);
    chk("blank keys mode_en", int'(mode_en), 4);
    dwell_sw = 4'd5;
    go(1);
    chk("mid-slot dwell_sw", int'(dwell_left), 3);
    next_pulse = 1'b1; go(1); next_pulse = 1'b0;
    go(16);
    chk("new dwell_sw applied", int'(dwell_left), 6);
    dwell_sw = 4'd2;

    pause_pulse = 1'b1; go(1); pause_pulse = 1'b0;
    next_pulse = 1'b1; go(1); next_pulse = 1'b0;
    go(4);
    rst_in = 1'b1; go(1);
    rst_in = 1'b0;
    chk("rst mode", int'(mode_out), 0);
    chk("rst blank", int'(blank_out), 1);
    chk("rst paused", int'(paused_out), 0);
    chk("rst dwell", int'(dwell_left), 0);
    go(15);
    chk("rst full blank", int'(blank_out), 1);
    go(1);
    chk("rst exit mode_en", int'(mode_en), 1);
    chk("rst exit chg", int'(mode_chg_pulse), 1);

    for (int i = 0; i < 20; i++) begin
      tick_in = 1'b1; go(1); tick_in = 1'b0; go(19);
    end
`ifndef SEQ_AUTO_ADVANCE_EN
    chk("ticks ignored mode", int'(mode_out), 0);
    chk("ticks ignored dwell", int'(dwell_left), 3);
`endif

    for (int i = 0; i < 600; i++) begin
      next_pulse  = ($urandom_range(0, 39) == 0);
      prev_pulse  = ($urandom_range(0, 39) == 0);
      pause_pulse = ($urandom_range(0, 59) == 0);
      tick_in     = ($urandom_range(0, 4) == 0);
      dwell_sw    = 4'($urandom_range(0, 3));
      go(1);
    end
    next_pulse = 1'b0; prev_pulse = 1'b0; pause_pulse = 1'b0; tick_in = 1'b0;
    go(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
